alu_mc: RTL and testbench

//  Parametrised multi-cycle RV32I/RV32M execute unit with valid/ready handshakes on input and output.

---
 rtl/alu_mc.sv | 194 +++++++++++++++++++
 tb/tb_alu_mc.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/RV32M execute unit: single-cycle ALU ops, MUL_LAT-cycle multiply,
// iterative radix-2 divide/remainder, with valid/ready on both sides and one op in flight.
module alu_mc #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [4:0]       ctrl_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] y_o,
   output logic             cout_o,
   output logic             illegal_o
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + MUL_LAT + 1);

   typedef enum logic [2:0] {StIdle, StAlu, StMul, StDiv, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   logic [4:0]       ctrl_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic [WIDTH-1:0] y_q;
   logic             cout_q, illegal_q, out_valid_q, in_ready_q;

   // ALU datapath
   logic [WIDTH:0]    add_sum;
   logic [SW-1:0]     shamt;
   logic [WIDTH-1:0]  alu_y;
   logic              alu_c, alu_ill;

   assign shamt   = op_b_q[SW-1:0];
   assign add_sum = {1'b0, op_a_q} + {1'b0, (ctrl_q[4] ? ~op_b_q : op_b_q)}
                    + (WIDTH+1)'(ctrl_q[4]);

   always_comb begin
      alu_y   = '0;
      alu_c   = 1'b0;
      alu_ill = 1'b0;
      case (ctrl_q)
         5'b00000, 5'b10000: {alu_c, alu_y} = add_sum;
         5'b00001: alu_y = op_a_q << shamt;
         5'b00010: alu_y = {{(WIDTH-1){1'b0}}, $signed(op_a_q) < $signed(op_b_q)};
         5'b00011: alu_y = {{(WIDTH-1){1'b0}}, op_a_q < op_b_q};
         5'b00100: alu_y = op_a_q ^ op_b_q;
         5'b00101: alu_y = op_a_q >> shamt;
         5'b00110: alu_y = op_a_q | op_b_q;
         5'b00111: alu_y = op_a_q & op_b_q;
         5'b10101: alu_y = WIDTH'($signed(op_a_q) >>> shamt);
         default:  alu_ill = 1'b1;
      endcase
   end

   // Multiply: operands sign/zero-extended to 2*WIDTH so one unsigned product serves all four
   logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, mul_prod;
   logic [WIDTH-1:0]   mul_y;
   logic               mul_a_sgn, mul_b_sgn;

   assign mul_a_sgn = (ctrl_q[1:0] != 2'b11) & op_a_q[WIDTH-1];
   assign mul_b_sgn = ~ctrl_q[1] & op_b_q[WIDTH-1];
   assign mul_a_ext = {{WIDTH{mul_a_sgn}}, op_a_q};
   assign mul_b_ext = {{WIDTH{mul_b_sgn}}, op_b_q};
   assign mul_prod  = mul_a_ext * mul_b_ext;
   assign mul_y     = (ctrl_q[1:0] == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];

   // Divide: restoring radix-2 on magnitudes, sign fixed up in the final cycle
   logic             in_sgn;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_t, diff;
   logic             div_sgn, is_rem, q_neg, r_neg;
   logic [WIDTH-1:0] div_y;

   assign in_sgn  = ~ctrl_i[0];
   assign a_mag   = (in_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag   = (in_sgn && b_i[WIDTH-1]) ? -b_i : b_i;
   assign rem_t   = {rem_q, quo_q[WIDTH-1]};
   assign diff    = rem_t - {1'b0, dvs_q};
   assign div_sgn = ~ctrl_q[0];
   assign is_rem  = ctrl_q[1];
   assign q_neg   = div_sgn & (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
   assign r_neg   = div_sgn & op_a_q[WIDTH-1];

   always_comb begin
      div_y = '0;
      if (op_b_q == '0) begin
         div_y = is_rem ? op_a_q : '1;
      end else if (is_rem) begin
         div_y = r_neg ? -rem_q : rem_q;
      end else begin
         div_y = q_neg ? -quo_q : quo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_a_q      <= '0;
         op_b_q      <= '0;
         ctrl_q      <= '0;
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         y_q         <= '0;
         cout_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  op_a_q     <= a_i;
                  op_b_q     <= b_i;
                  ctrl_q     <= ctrl_i;
                  cnt_q      <= '0;
                  quo_q      <= a_mag;
                  rem_q      <= '0;
                  dvs_q      <= b_mag;
                  in_ready_q <= 1'b0;
                  if (ctrl_i[4:3] == 2'b01) begin
                     state_q <= ctrl_i[2] ? StDiv : StMul;
                  end else begin
                     state_q <= StAlu;
                  end
               end
            end
            StAlu: begin
               y_q         <= alu_ill ? '0 : alu_y;
               cout_q      <= alu_c;
               illegal_q   <= alu_ill;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StMul: begin
               if (cnt_q == CW'(MUL_LAT - 1)) begin
                  y_q         <= mul_y;
                  cout_q      <= 1'b0;
                  illegal_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDiv: begin
               if (cnt_q == CW'(WIDTH)) begin
                  y_q         <= div_y;
                  cout_q      <= 1'b0;
                  illegal_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (!diff[WIDTH]) begin
                     rem_q <= diff[WIDTH-1:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_q <= rem_t[WIDTH-1:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                  end
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign y_o         = y_q;
   assign cout_o      = cout_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vectors, randomized ops against an arithmetic reference model,
// backpressure, back-to-back handshake and mid-divide reset.
module tb_alu_mc;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, y;
   logic [4:0]    ctrl;
   logic          cout, illegal;

   int total = 0;
   int bad   = 0;

   alu_mc #(.WIDTH(W), .MUL_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .ctrl_i      (ctrl),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .y_o         (y),
      .cout_o      (cout),
      .illegal_o   (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   localparam logic [4:0] LEGAL [18] = '{
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b10000, 5'b10101};

   // Reference: results from plain 64-bit arithmetic and the architectural special-case rules
   function automatic void model(input logic [4:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 output logic [W-1:0] ey, output logic ec, output logic ei);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic [4:0]  sh;
      logic        ovf;
      sa  = longint'($signed(av));
      sb  = longint'($signed(bv));
      ua  = longint'({32'h0, av});
      ub  = longint'({32'h0, bv});
      sh  = bv[4:0];
      ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
      ey  = '0;
      ec  = 1'b0;
      ei  = 1'b0;
      case (c)
         5'b00000: begin p = ua + ub; ey = p[31:0]; ec = p[32]; end
         5'b10000: begin ey = av - bv; ec = (av >= bv); end
         5'b00001: ey = av << sh;
         5'b00010: ey = {31'b0, sa < sb};
         5'b00011: ey = {31'b0, av < bv};
         5'b00100: ey = av ^ bv;
         5'b00101: ey = av >> sh;
         5'b00110: ey = av | bv;
         5'b00111: ey = av & bv;
         5'b10101: begin p = sa >>> sh; ey = p[31:0]; end
         5'b01000: begin p = sa * sb; ey = p[31:0]; end
         5'b01001: begin p = sa * sb; ey = p[63:32]; end
         5'b01010: begin p = sa * ub; ey = p[63:32]; end
         5'b01011: begin p = ua * ub; ey = p[63:32]; end
         5'b01100: begin
            if (bv == 0) ey = '1;
            else if (ovf) ey = av;
            else begin p = sa / sb; ey = p[31:0]; end
         end
         5'b01101: begin
            if (bv == 0) ey = '1;
            else begin p = ua / ub; ey = p[31:0]; end
         end
         5'b01110: begin
            if (bv == 0) ey = av;
            else if (ovf) ey = '0;
            else begin p = sa % sb; ey = p[31:0]; end
         end
         5'b01111: begin
            if (bv == 0) ey = av;
            else begin p = ua % ub; ey = p[31:0]; end
         end
         default: ei = 1'b1;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] c);
      if (c[4:3] == 2'b01) return c[2] ? W + 1 : LAT;
      return 1;
   endfunction

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         4:       return W'($urandom_range(0, 40));
         default: return W'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE, wait (bounded) for out_valid, capture outputs, then consume them.
   task automatic run_op(input logic [4:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic [W-1:0] yo, output logic co, output logic il);
      in_valid = 1'b1;
      ctrl     = c;
      a        = av;
      b        = bv;
      tick();
      in_valid = 1'b0;
      ctrl     = 5'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      lat      = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      yo        = y;
      co        = cout;
      il        = illegal;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      ctrl      = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (y !== '0) begin bad++; $display("FAIL reset_y got=%h want=0", y); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
   endtask

   typedef struct {
      logic [4:0]   c;
      logic [W-1:0] av, bv, ey;
      logic         ec, ei;
   } vec_t;

   task automatic test_directed();
      vec_t v [13] = '{
         '{5'b00000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0},
         '{5'b10000, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0},
         '{5'b10101, 32'h8000_0000, 32'h3F,        32'hFFFF_FFFF, 1'b0, 1'b0},
         '{5'b00010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0},
         '{5'b00011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0},
         '{5'b01001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0},
         '{5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0},
         '{5'b01100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 1'b0},
         '{5'b01110, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, 1'b0},
         '{5'b01101, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0},
         '{5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0},
         '{5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0},
         '{5'b11000, 32'hDEAD_BEEF, 32'h1,         32'h0,         1'b0, 1'b1}
      };
      int lat;
      logic [W-1:0] yo;
      logic co, il;
      foreach (v[i]) begin
         run_op(v[i].c, v[i].av, v[i].bv, lat, yo, co, il);
         total++; if (yo !== v[i].ey) begin bad++;
            $display("FAIL dir_y[%0d] ctrl=%b got=%h want=%h", i, v[i].c, yo, v[i].ey); end
         total++; if (co !== v[i].ec) begin bad++;
            $display("FAIL dir_cout[%0d] ctrl=%b got=%b want=%b", i, v[i].c, co, v[i].ec); end
         total++; if (il !== v[i].ei) begin bad++;
            $display("FAIL dir_illegal[%0d] ctrl=%b got=%b want=%b", i, v[i].c, il, v[i].ei); end
         total++; if (lat != exp_lat(v[i].c)) begin bad++;
            $display("FAIL dir_lat[%0d] ctrl=%b got=%0d want=%0d", i, v[i].c, lat, exp_lat(v[i].c)); end
      end
   endtask

   // group: 0 = ALU/illegal codes, 1 = mul*, 2 = div/rem
   task automatic test_random(input int group, input int n);
      int lat;
      logic [4:0] c;
      logic [W-1:0] av, bv, yo, ey;
      logic co, il, ec, ei;
      for (int k = 0; k < n; k++) begin
         case (group)
            0: begin
               c = 5'($urandom);
               if (c[4:3] == 2'b01) c = LEGAL[$urandom_range(0, 7)];
            end
            1: c = {3'b010, 2'($urandom)};
            default: c = {3'b011, 2'($urandom)};
         endcase
         av = rand_opnd();
         bv = rand_opnd();
         model(c, av, bv, ey, ec, ei);
         run_op(c, av, bv, lat, yo, co, il);
         total++;
         if (yo !== ey || co !== ec || il !== ei || lat != exp_lat(c)) begin
            bad++;
            $display("FAIL rand_g%0d ctrl=%b a=%h b=%h got y=%h c=%b il=%b lat=%0d want y=%h c=%b il=%b lat=%0d",
                     group, c, av, bv, yo, co, il, lat, ey, ec, ei, exp_lat(c));
         end
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] held, ey;
      logic ec, ei;
      logic seen, stable;
      model(5'b01011, 32'hFFFF_FFFF, 32'h0000_0003, ey, ec, ei);
      in_valid = 1'b1;
      ctrl     = 5'b01011;
      a        = 32'hFFFF_FFFF;
      b        = 32'h0000_0003;
      tick();
      in_valid = 1'b0;
      seen     = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = out_valid;
      end
      total++; if (!seen) begin bad++; $display("FAIL hold_valid got=0 want=1"); end
      held   = y;
      stable = 1'b1;
      in_valid = 1'b1;
      ctrl     = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (y !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      in_valid = 1'b0;
      total++; if (!stable) begin bad++;
         $display("FAIL hold_stable y=%h held=%h ov=%b ir=%b", y, held, out_valid, in_ready); end
      total++; if (held !== ey) begin bad++; $display("FAIL hold_y got=%h want=%h", held, ey); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
         $display("FAIL hold_release ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [W-1:0] ey;
      logic ec, ei;
      in_valid = 1'b1;
      ctrl     = 5'b00100;
      a        = 32'hF0F0_0000;
      b        = 32'h0FF0_1234;
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1 || y !== 32'hFF00_1234) begin bad++;
         $display("FAIL b2b_first ov=%b y=%h want ov=1 y=ff001234", out_valid, y); end
      // consume and present a new op in the same DONE cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      ctrl      = 5'b00001;
      a         = 32'h0000_0003;
      b         = 32'h0000_0004;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_done got=%b want=0", in_ready); end
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
         $display("FAIL b2b_idle ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept in_ready=%b want=0", in_ready); end
      model(5'b00001, 32'h3, 32'h4, ey, ec, ei);
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (out_valid) begin lat = i; break; end
      end
      total++; if (lat != 1 || y !== ey) begin bad++;
         $display("FAIL b2b_second lat=%0d y=%h want lat=1 y=%h", lat, y, ey); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_div();
      logic stale;
      int lat;
      logic [W-1:0] yo, ey;
      logic co, il, ec, ei;
      in_valid = 1'b1;
      ctrl     = 5'b01100;
      a        = 32'h0000_1000;
      b        = 32'h0000_0003;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== '0) begin bad++;
         $display("FAIL rst_mid_outputs ov=%b ir=%b y=%h want 0/1/0", out_valid, in_ready, y); end
      tick();
      rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      total++; if (stale) begin bad++; $display("FAIL rst_mid_stale out_valid seen=1 want=0"); end
      model(5'b01111, 32'h0000_0064, 32'h0000_0007, ey, ec, ei);
      run_op(5'b01111, 32'h0000_0064, 32'h0000_0007, lat, yo, co, il);
      total++; if (yo !== ey || lat != W + 1) begin bad++;
         $display("FAIL rst_mid_recover y=%h lat=%0d want y=%h lat=%0d", yo, lat, ey, W + 1); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(0, 120);
      test_random(1, 60);
      test_random(2, 60);
      test_hold();
      test_back_to_back();
      test_reset_mid_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
